// File: rtl/pcie_tx_arbiter_if.sv
// rtl/pcie_tx_arbiter_if.sv - requester-side and core-side TX stream bundle for the arbiter
// master drives the requester streams and core tready; slave is the arbiter.
interface pcie_tx_arbiter_if;
  logic [95:0] i_req_tdata;
  logic [11:0] i_req_tkeep;
  logic [11:0] i_req_tuser;
  logic [2:0]  i_req_tlast;
  logic [2:0]  i_req_tvalid;
  logic [2:0]  o_req_tready;
  logic [31:0] s_axis_tx_tdata;
  logic [3:0]  s_axis_tx_tkeep;
  logic [3:0]  s_axis_tx_tuser;
  logic        s_axis_tx_tlast;
  logic        s_axis_tx_tvalid;
  logic        s_axis_tx_tready;

  modport master (
    output i_req_tdata, i_req_tkeep, i_req_tuser, i_req_tlast, i_req_tvalid,
    output s_axis_tx_tready,
    input  o_req_tready,
    input  s_axis_tx_tdata, s_axis_tx_tkeep, s_axis_tx_tuser, s_axis_tx_tlast, s_axis_tx_tvalid
  );

  modport slave (
    input  i_req_tdata, i_req_tkeep, i_req_tuser, i_req_tlast, i_req_tvalid,
    input  s_axis_tx_tready,
    output o_req_tready,
    output s_axis_tx_tdata, s_axis_tx_tkeep, s_axis_tx_tuser, s_axis_tx_tlast, s_axis_tx_tvalid
  );
endinterface

// File: rtl/pcie_tx_arbiter.sv
// rtl/pcie_tx_arbiter.sv - packet-granular round-robin arbiter for the PCIe core TX stream
// Three requesters share one core port; config-TLP requests are granted between packets.
module pcie_tx_arbiter #(
  parameter int BUF_AV_MIN = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              user_lnk_up,
  input  logic [5:0]        tx_buf_av,
  input  logic              tx_err_drop,
  input  logic              tx_cfg_req,
  output logic              tx_cfg_gnt,
  pcie_tx_arbiter_if.slave  bus,
  output logic [2:0]        o_grant,
  output logic              o_abort,
  output logic [15:0]       o_pkt_count,
  output logic [7:0]        o_drop_count
);

  typedef enum logic [1:0] {IDLE, CFG, XFER} state_t;

  state_t     state, next_state;
  logic [1:0] last_grant;
  logic [1:0] gidx;
  logic [1:0] c0, c1, c2;
  logic [1:0] pick;
  logic       can_start;
  logic       xfer_beat;

  // Search order starts just after the last served requester.
  always_comb begin
    case (last_grant)
      2'd0:    {c0, c1, c2} = {2'd1, 2'd2, 2'd0};
      2'd1:    {c0, c1, c2} = {2'd2, 2'd0, 2'd1};
      default: {c0, c1, c2} = {2'd0, 2'd1, 2'd2};
    endcase
    pick = bus.i_req_tvalid[c0] ? c0 : (bus.i_req_tvalid[c1] ? c1 : c2);
  end

  always_comb begin
    gidx = 2'd0;
    if (o_grant[1]) gidx = 2'd1;
    if (o_grant[2]) gidx = 2'd2;
  end

  assign can_start = user_lnk_up && (tx_buf_av >= 6'(BUF_AV_MIN)) && (|bus.i_req_tvalid);
  assign xfer_beat = bus.s_axis_tx_tvalid && bus.s_axis_tx_tready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (tx_cfg_req)     next_state = CFG;
        else if (can_start) next_state = XFER;
      end
      CFG:  if (!tx_cfg_req) next_state = IDLE;
      XFER: begin
        if (!user_lnk_up)                           next_state = IDLE;
        else if (xfer_beat && bus.s_axis_tx_tlast)  next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Datapath mux: only the granted requester sees the core's tready.
  always_comb begin
    bus.s_axis_tx_tdata  = '0;
    bus.s_axis_tx_tkeep  = '0;
    bus.s_axis_tx_tuser  = '0;
    bus.s_axis_tx_tlast  = 1'b0;
    bus.s_axis_tx_tvalid = 1'b0;
    bus.o_req_tready     = '0;
    if (state == XFER) begin
      for (int r = 0; r < 3; r++) begin
        if (o_grant[r]) begin
          bus.s_axis_tx_tdata  = bus.i_req_tdata[32*r +: 32];
          bus.s_axis_tx_tkeep  = bus.i_req_tkeep[4*r +: 4];
          bus.s_axis_tx_tuser  = bus.i_req_tuser[4*r +: 4];
          bus.s_axis_tx_tlast  = bus.i_req_tlast[r];
          bus.s_axis_tx_tvalid = bus.i_req_tvalid[r];
          bus.o_req_tready[r]  = bus.s_axis_tx_tready;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_grant      <= 3'b000;
      last_grant   <= 2'd2;
      tx_cfg_gnt   <= 1'b0;
      o_abort      <= 1'b0;
      o_pkt_count  <= 16'd0;
      o_drop_count <= 8'd0;
    end else begin
      o_abort    <= 1'b0;
      tx_cfg_gnt <= (next_state == CFG);
      case (state)
        IDLE: if (next_state == XFER) o_grant <= 3'b001 << pick;
        XFER: begin
          // An aborted requester is treated as served so it loses its turn.
          if (!user_lnk_up) begin
            o_grant    <= 3'b000;
            last_grant <= gidx;
            o_abort    <= 1'b1;
          end else if (xfer_beat && bus.s_axis_tx_tlast) begin
            o_grant     <= 3'b000;
            last_grant  <= gidx;
            o_pkt_count <= o_pkt_count + 16'd1;
          end
        end
        default: ;
      endcase
      if (tx_err_drop && (o_drop_count != 8'hFF))
        o_drop_count <= o_drop_count + 8'd1;
    end
  end

endmodule
